mem_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It performs loads and stores over a request/acknowledge data bus and requests a pipeline stall while a transfer is outstanding. Non-memory instructions pass through unchanged to the MEM/WB register.

---
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage : MIPS memory-access stage, loads/stores over a req/ack bus    |
// |             with stall request. Optional LL/SC support: MEM_LLSC_EN.     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_wd,
  input  logic        i_wreg,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic        i_whilo,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stallreq
);

  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;
`ifdef MEM_LLSC_EN
  localparam logic [3:0] c_OP_LL  = 4'd9;
  localparam logic [3:0] c_OP_SC  = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q, op_q;
  logic [1:0]  off_q;
`ifdef MEM_LLSC_EN
  logic        llbit_q;
`endif

  logic        w_load, w_store, w_mem, w_sc_fail, w_byte, w_half, w_ret;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_load_val;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  // Request-side decode from the EX/MEM inputs (held stable while stalled).
  always_comb begin
    w_load    = (i_op >= c_OP_LB) && (i_op <= c_OP_LW);
    w_store   = (i_op == c_OP_SB) || (i_op == c_OP_SH) || (i_op == c_OP_SW);
    w_sc_fail = 1'b0;
`ifdef MEM_LLSC_EN
    if (i_op == c_OP_LL) w_load = 1'b1;
    if (i_op == c_OP_SC) begin
      w_store   = llbit_q;
      w_sc_fail = !llbit_q;
    end
`endif
    w_mem  = w_load || w_store;
    w_byte = (i_op == c_OP_LB) || (i_op == c_OP_LBU) || (i_op == c_OP_SB);
    w_half = (i_op == c_OP_LH) || (i_op == c_OP_LHU) || (i_op == c_OP_SH);
    if (w_byte)      w_sel = 4'b1000 >> i_addr[1:0];
    else if (w_half) w_sel = i_addr[1] ? 4'b0011 : 4'b1100;
    else             w_sel = 4'b1111;
    if (i_op == c_OP_SB)      w_wdata = {4{i_store_data[7:0]}};
    else if (i_op == c_OP_SH) w_wdata = {2{i_store_data[15:0]}};
    else                      w_wdata = i_store_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_mem) state_d = S_REQ;
      S_REQ:   if (dbus_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane extraction uses the op/offset latched at request time.
  always_comb begin
    case (off_q)
      2'd0:    w_b = dbus_rdata[31:24];
      2'd1:    w_b = dbus_rdata[23:16];
      2'd2:    w_b = dbus_rdata[15:8];
      default: w_b = dbus_rdata[7:0];
    endcase
    w_h = off_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
    case (op_q)
      c_OP_LB:  w_load_val = {{24{w_b[7]}}, w_b};
      c_OP_LBU: w_load_val = {24'd0, w_b};
      c_OP_LH:  w_load_val = {{16{w_h[15]}}, w_h};
      c_OP_LHU: w_load_val = {16'd0, w_h};
`ifdef MEM_LLSC_EN
      c_OP_SC:  w_load_val = 32'd1;
`endif
      default:  w_load_val = dbus_rdata;
    endcase
    w_ret = (op_q >= c_OP_LB) && (op_q <= c_OP_LW);
`ifdef MEM_LLSC_EN
    if ((op_q == c_OP_LL) || (op_q == c_OP_SC)) w_ret = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      op_q    <= 4'd0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && w_mem) begin
        req_q   <= 1'b1;
        we_q    <= w_store;
        addr_q  <= {i_addr[31:2], 2'b00};
        sel_q   <= w_sel;
        wdata_q <= w_wdata;
        op_q    <= i_op;
        off_q   <= i_addr[1:0];
      end
      if ((state_q == S_REQ) && dbus_ack) begin
        req_q   <= 1'b0;
        rdata_q <= w_load_val;
      end
    end
  end

`ifdef MEM_LLSC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_q <= 1'b0;
    end else if ((state_q == S_REQ) && dbus_ack) begin
      if (op_q == c_OP_LL)      llbit_q <= 1'b1;
      else if (op_q == c_OP_SC) llbit_q <= 1'b0;
    end
  end
`endif

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;

  always_comb begin
    mem_wd    = i_wd;
    mem_wreg  = i_wreg;
    mem_wdata = i_wdata;
    mem_hi    = i_hi;
    mem_lo    = i_lo;
    mem_whilo = i_whilo;
    stallreq  = ((state_q == S_IDLE) && w_mem) || (state_q == S_REQ);
    if ((state_q == S_IDLE) && w_sc_fail) mem_wdata = 32'd0;
    if ((state_q == S_DONE) && w_ret)     mem_wdata = rdata_q;
    if (rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
      mem_hi    = 32'd0;
      mem_lo    = 32'd0;
      mem_whilo = 1'b0;
      stallreq  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage : randomized self-checking bench for mem_stage              |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  i_wd;
  logic        i_wreg;
  logic [31:0] i_wdata, i_hi, i_lo;
  logic        i_whilo;
  logic [3:0]  i_op;
  logic [31:0] i_addr, i_store_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_sel;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, stallreq;
  logic [31:0] mem_wdata, mem_hi, mem_lo;

  int n_checks = 0;
  int n_errors = 0;
  bit m_llbit  = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .i_wd(i_wd), .i_wreg(i_wreg), .i_wdata(i_wdata), .i_hi(i_hi), .i_lo(i_lo),
    .i_whilo(i_whilo), .i_op(i_op), .i_addr(i_addr), .i_store_data(i_store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .stallreq(stallreq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: op classification and bus/result values from the rules.
  function automatic bit m_is_mem(input int op);
    if (op >= 1 && op <= 8) return 1'b1;
`ifdef MEM_LLSC_EN
    if (op == 9)  return 1'b1;
    if (op == 10) return m_llbit;
`endif
    return 1'b0;
  endfunction

  function automatic bit m_is_store(input int op);
    return (op >= 6 && op <= 8) || (op == 10);
  endfunction

  function automatic logic [3:0] m_sel(input int op, input logic [31:0] addr);
    int idx;
    idx = int'(addr & 32'd3);
    if (op == 1 || op == 2 || op == 6) return 4'(1 << (3 - idx));
    if (op == 3 || op == 4 || op == 7) return (idx >= 2) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] rt);
    if (op == 6) return (rt & 32'hFF) * 32'h01010101;
    if (op == 7) return (rt & 32'hFFFF) * 32'h00010001;
    return rt;
  endfunction

  function automatic logic [31:0] m_result(input int op, input logic [31:0] addr,
                                           input logic [31:0] rd, input logic [31:0] alu);
    logic [31:0] v;
    int idx;
    idx = int'(addr & 32'd3);
    v = alu;
    case (op)
      1, 2: begin
        v = (rd >> (8 * (3 - idx))) & 32'hFF;
        if (op == 1 && v >= 32'd128) v = v - 32'd256;
      end
      3, 4: begin
        v = (idx >= 2) ? (rd & 32'hFFFF) : (rd >> 16);
        if (op == 3 && v >= 32'd32768) v = v - 32'd65536;
      end
      5: v = rd;
`ifdef MEM_LLSC_EN
      9:  v = rd;
      10: v = 32'd1;
`endif
      default: v = alu;
    endcase
    return v;
  endfunction

  // Starts just after a posedge with the DUT idle; ends the same way.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rd, input int k, input logic [31:0] alu,
                       input logic [4:0] wd);
    bit mem, sc_fail, wreg, whilo;
    logic [31:0] hi, lo;
    int stalls;
    mem     = m_is_mem(int'(op));
    sc_fail = 1'b0;
`ifdef MEM_LLSC_EN
    sc_fail = (op == 4'd10) && !m_llbit;
`endif
    hi = $urandom; lo = $urandom;
    wreg = 1'($urandom_range(0, 1)); whilo = 1'($urandom_range(0, 1));
    i_op = op; i_addr = addr; i_store_data = rt; i_wdata = alu; i_wd = wd;
    i_wreg = wreg; i_hi = hi; i_lo = lo; i_whilo = whilo;
    dbus_ack = mem ? 1'b0 : 1'($urandom_range(0, 1));
    dbus_rdata = $urandom;
    stalls = 0;
    @(negedge clk);
    if (stallreq) stalls++;
    check("idle_stall", {31'd0, stallreq}, {31'd0, mem});
    check("idle_req", {31'd0, dbus_req}, 32'd0);
    check("idle_wdata", mem_wdata, sc_fail ? 32'd0 : alu);
    check("pass_wd", {27'd0, mem_wd}, {27'd0, wd});
    check("pass_wreg", {31'd0, mem_wreg}, {31'd0, wreg});
    check("pass_hi", mem_hi, hi);
    check("pass_lo", mem_lo, lo);
    check("pass_whilo", {31'd0, mem_whilo}, {31'd0, whilo});
    if (mem) begin
      for (int j = 1; j <= k; j++) begin
        @(posedge clk); #1;
        dbus_ack   = (j == k);
        dbus_rdata = (j == k) ? rd : $urandom;
        @(negedge clk);
        if (stallreq) stalls++;
        check("req_high", {31'd0, dbus_req}, 32'd1);
        if (j == 1) begin
          check("bus_addr", dbus_addr, addr & 32'hFFFFFFFC);
          check("bus_sel", {28'd0, dbus_sel}, {28'd0, m_sel(int'(op), addr)});
          check("bus_we", {31'd0, dbus_we}, {31'd0, m_is_store(int'(op))});
          if (m_is_store(int'(op))) check("bus_wdata", dbus_wdata, m_wdata(int'(op), rt));
        end
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      dbus_rdata = $urandom;
      @(negedge clk);
      check("done_req", {31'd0, dbus_req}, 32'd0);
      check("done_stall", {31'd0, stallreq}, 32'd0);
      check("done_wdata", mem_wdata, m_result(int'(op), addr, rd, alu));
      check("stall_cycles", 32'(stalls), 32'(k + 1));
      if (op == 4'd9)  m_llbit = 1'b1;
      if (op == 4'd10) m_llbit = 1'b0;
    end else begin
      check("stall_cycles", 32'(stalls), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; i_op = 4'd5; i_addr = 32'h40; i_store_data = 32'd0;
    i_wdata = 32'hDEADBEEF; i_wd = 5'd7; i_wreg = 1'b1; i_hi = 32'h1; i_lo = 32'h2;
    i_whilo = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, dbus_req}, 32'd0);
    check("rst_stall", {31'd0, stallreq}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wd", {27'd0, mem_wd}, 32'd0);
    check("rst_hi", mem_hi, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; i_op = 4'd0;

    do_op(4'd0, 32'd0, 32'd0, 32'd0, 1, 32'h1234, 5'd5);
    do_op(4'd1, 32'h103, 32'd0, 32'h112233F0, 3, 32'h9, 5'd3);
    do_op(4'd2, 32'h103, 32'd0, 32'h112233F0, 3, 32'h9, 5'd3);
    do_op(4'd7, 32'h202, 32'hAAAA5678, 32'd0, 1, 32'h0, 5'd0);
    do_op(4'd5, 32'h404, 32'd0, 32'h89ABCDEF, 2, 32'h77, 5'd8);
    do_op(4'd8, 32'h408, 32'hCAFEF00D, 32'd0, 1, 32'h66, 5'd0);
    do_op(4'd9, 32'h300, 32'd0, 32'h0BADF00D, 2, 32'h11, 5'd4);
    do_op(4'd10, 32'h300, 32'h13572468, 32'd0, 1, 32'h22, 5'd4);
    do_op(4'd10, 32'h300, 32'h13572468, 32'd0, 1, 32'h33, 5'd4);

    // Reset in the middle of a transfer, then a stray ack.
    i_op = 4'd1; i_addr = 32'h50; i_wdata = 32'h44; i_wd = 5'd9;
    dbus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req", {31'd0, dbus_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", {31'd0, stallreq}, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_wd", {27'd0, mem_wd}, 32'd0);
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("post_rst_req", {31'd0, dbus_req}, 32'd0);
    check("post_rst_wdata", mem_wdata, 32'd0);
    m_llbit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; i_op = 4'd0; i_wdata = 32'h55;
    @(negedge clk);
    check("late_ack_req", {31'd0, dbus_req}, 32'd0);
    check("late_ack_stall", {31'd0, stallreq}, 32'd0);
    check("late_ack_wdata", mem_wdata, 32'h55);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req2", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
            $urandom_range(1, 4), $urandom, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
